// File: rtl/alarm_pkg_57.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg_57 (package)
// Description : Shared FSM state encoding and parameter defaults for the
//               alarm controller and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg_57;

  // Alarm controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  localparam int c_RING_SEC_DEF   = 60;
  localparam int c_SNOOZE_SEC_DEF = 300;
  localparam int c_MAX_SNOOZE_DEF = 3;
  localparam int c_BEEP_DIV_DEF   = 12_500_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_57.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_57
// Description : Rising-edge detector for a debounced level key. A held key
//               produces a single one-cycle pulse.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               key  - debounced key level
//               rise - one-cycle pulse on 0->1 transition of key
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_57 (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise
);

  logic r_key_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_d <= 1'b0;
    end else begin
      r_key_d <= key;
    end
  end

  assign rise = key & ~r_key_d;

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl_57.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ctrl_57
// Description : Alarm clock controller. Latches an alarm time, rings when the
//               current time matches on a second tick, supports stop and a
//               bounded number of snoozes, and drives a square-wave buzzer.
// Ports       : clk_50m_57       - system clock
//               rst_57           - asynchronous active-high reset
//               tick_1s_57       - one-cycle pulse per second
//               cur_*_57         - current time (sec/min/hour, binary)
//               set_*_57         - alarm time to latch
//               write_clock_e_57 - latch strobe for set_*_57 (level)
//               alarm_on_57      - alarm enable switch
//               key_stop_57      - stop key (debounced level)
//               key_snooze_57    - snooze key (debounced level)
//               ringing_57       - high while ringing
//               armed_57         - high while armed or snoozing
//               buzzer_57        - buzzer drive
//               snooze_cnt_57    - snoozes used in the current event
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl_57
  import alarm_pkg_57::*;
#(
  parameter int RING_SEC   = c_RING_SEC_DEF,
  parameter int SNOOZE_SEC = c_SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = c_MAX_SNOOZE_DEF,
  parameter int BEEP_DIV   = c_BEEP_DIV_DEF
) (
  input  logic       clk_50m_57,
  input  logic       rst_57,
  input  logic       tick_1s_57,
  input  logic [6:0] cur_sec_57,
  input  logic [6:0] cur_min_57,
  input  logic [6:0] cur_hour_57,
  input  logic [6:0] set_sec_57,
  input  logic [6:0] set_min_57,
  input  logic [6:0] set_hour_57,
  input  logic       write_clock_e_57,
  input  logic       alarm_on_57,
  input  logic       key_stop_57,
  input  logic       key_snooze_57,
  output logic       ringing_57,
  output logic       armed_57,
  output logic       buzzer_57,
  output logic [1:0] snooze_cnt_57
);

  localparam int c_SEC_W  = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
  localparam int c_BEEP_W = $clog2(BEEP_DIV + 1);

  localparam logic [c_SEC_W-1:0]  c_RING_LAST   = c_SEC_W'(RING_SEC - 1);
  localparam logic [c_SEC_W-1:0]  c_SNOOZE_LAST = c_SEC_W'(SNOOZE_SEC - 1);
  localparam logic [c_BEEP_W-1:0] c_BEEP_LAST   = c_BEEP_W'(BEEP_DIV - 1);
  localparam logic [1:0]          c_MAX_SNZ     = 2'(MAX_SNOOZE);

  alarm_state_e        r_state;
  alarm_state_e        w_state_nxt;
  logic [6:0]          r_alm_sec;
  logic [6:0]          r_alm_min;
  logic [6:0]          r_alm_hour;
  logic [c_SEC_W-1:0]  r_sec_cnt;
  logic [c_BEEP_W-1:0] r_beep_cnt;
  logic                r_toggle;
  logic [1:0]          r_snooze_cnt;
  logic [1:0]          w_snz_nxt;
  logic                w_sec_inc;
  logic                w_stop_rise;
  logic                w_snz_rise;
  logic                w_time_match;

  key_edge_57 u_stop_edge (
    .clk  (clk_50m_57),
    .rst  (rst_57),
    .key  (key_stop_57),
    .rise (w_stop_rise)
  );

  key_edge_57 u_snooze_edge (
    .clk  (clk_50m_57),
    .rst  (rst_57),
    .key  (key_snooze_57),
    .rise (w_snz_rise)
  );

  assign w_time_match = (cur_sec_57 == r_alm_sec) &&
                        (cur_min_57 == r_alm_min) &&
                        (cur_hour_57 == r_alm_hour);

  // Alarm time latch, independent of the FSM state
  always_ff @(posedge clk_50m_57 or posedge rst_57) begin
    if (rst_57) begin
      r_alm_sec  <= 7'd0;
      r_alm_min  <= 7'd0;
      r_alm_hour <= 7'd0;
    end else if (write_clock_e_57) begin
      r_alm_sec  <= set_sec_57;
      r_alm_min  <= set_min_57;
      r_alm_hour <= set_hour_57;
    end
  end

  // Next-state logic. Within RINGING: stop beats snooze, and a snooze at the
  // limit falls through so the timeout still applies in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_snz_nxt   = r_snooze_cnt;
    w_sec_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (alarm_on_57) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (tick_1s_57 && w_time_match) begin
          w_state_nxt = ST_RINGING;
          w_snz_nxt   = 2'd0;
        end
      end
      ST_RINGING: begin
        if (w_stop_rise) begin
          w_state_nxt = ST_ARMED;
          w_snz_nxt   = 2'd0;
        end else if (w_snz_rise && (r_snooze_cnt < c_MAX_SNZ)) begin
          w_state_nxt = ST_SNOOZE;
          w_snz_nxt   = r_snooze_cnt + 2'd1;
        end else if (tick_1s_57) begin
          if (r_sec_cnt == c_RING_LAST) begin
            w_state_nxt = ST_ARMED;
            w_snz_nxt   = 2'd0;
          end else begin
            w_sec_inc = 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (w_stop_rise) begin
          w_state_nxt = ST_ARMED;
          w_snz_nxt   = 2'd0;
        end else if (tick_1s_57) begin
          if (r_sec_cnt == c_SNOOZE_LAST) begin
            w_state_nxt = ST_RINGING;
          end else begin
            w_sec_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Disabling the alarm overrides everything else
    if (!alarm_on_57) w_state_nxt = ST_IDLE;
  end

  // State, second counter and snooze count
  always_ff @(posedge clk_50m_57 or posedge rst_57) begin
    if (rst_57) begin
      r_state      <= ST_IDLE;
      r_sec_cnt    <= '0;
      r_snooze_cnt <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_snooze_cnt <= w_snz_nxt;
      if (w_state_nxt != r_state) begin
        r_sec_cnt <= '0;
      end else if (w_sec_inc) begin
        r_sec_cnt <= r_sec_cnt + 1'b1;
      end
    end
  end

  // Buzzer divider: starts high on RINGING entry, flips every BEEP_DIV cycles
  always_ff @(posedge clk_50m_57 or posedge rst_57) begin
    if (rst_57) begin
      r_beep_cnt <= '0;
      r_toggle   <= 1'b0;
    end else if ((w_state_nxt == ST_RINGING) && (r_state != ST_RINGING)) begin
      r_beep_cnt <= '0;
      r_toggle   <= 1'b1;
    end else if (r_state == ST_RINGING) begin
      if (r_beep_cnt == c_BEEP_LAST) begin
        r_beep_cnt <= '0;
        r_toggle   <= ~r_toggle;
      end else begin
        r_beep_cnt <= r_beep_cnt + 1'b1;
      end
    end else begin
      r_beep_cnt <= '0;
      r_toggle   <= 1'b0;
    end
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // silences them without waiting for a clock edge.
  assign ringing_57    = (r_state == ST_RINGING);
  assign armed_57      = (r_state == ST_ARMED) || (r_state == ST_SNOOZE);
  assign buzzer_57     = r_toggle & ringing_57;
  assign snooze_cnt_57 = r_snooze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl_57.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ctrl_57
// Description : Directed self-checking bench for alarm_ctrl_57 with short
//               timing parameters (BEEP_DIV=4, RING_SEC=5, SNOOZE_SEC=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl_57;

  logic       clk_50m_57 = 1'b0;
  logic       rst_57;
  logic       tick_1s_57;
  logic [6:0] cur_sec_57, cur_min_57, cur_hour_57;
  logic [6:0] set_sec_57, set_min_57, set_hour_57;
  logic       write_clock_e_57;
  logic       alarm_on_57;
  logic       key_stop_57;
  logic       key_snooze_57;
  logic       ringing_57;
  logic       armed_57;
  logic       buzzer_57;
  logic [1:0] snooze_cnt_57;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl_57 #(
    .RING_SEC   (5),
    .SNOOZE_SEC (3),
    .MAX_SNOOZE (3),
    .BEEP_DIV   (4)
  ) u_dut (
    .clk_50m_57       (clk_50m_57),
    .rst_57           (rst_57),
    .tick_1s_57       (tick_1s_57),
    .cur_sec_57       (cur_sec_57),
    .cur_min_57       (cur_min_57),
    .cur_hour_57      (cur_hour_57),
    .set_sec_57       (set_sec_57),
    .set_min_57       (set_min_57),
    .set_hour_57      (set_hour_57),
    .write_clock_e_57 (write_clock_e_57),
    .alarm_on_57      (alarm_on_57),
    .key_stop_57      (key_stop_57),
    .key_snooze_57    (key_snooze_57),
    .ringing_57       (ringing_57),
    .armed_57         (armed_57),
    .buzzer_57        (buzzer_57),
    .snooze_cnt_57    (snooze_cnt_57)
  );

  always #5 clk_50m_57 = ~clk_50m_57;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m_57);
    #1;
  endtask

  task automatic tick();
    tick_1s_57 = 1'b1;
    step();
    tick_1s_57 = 1'b0;
  endtask

  task automatic set_cur(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    cur_hour_57 = h;
    cur_min_57  = m;
    cur_sec_57  = s;
  endtask

  initial begin
    rst_57 = 1'b1;
    tick_1s_57 = 1'b0;
    set_cur(7'd0, 7'd0, 7'd1);
    set_hour_57 = 7'd7; set_min_57 = 7'd30; set_sec_57 = 7'd0;
    write_clock_e_57 = 1'b0;
    alarm_on_57 = 1'b0;
    key_stop_57 = 1'b0;
    key_snooze_57 = 1'b0;
    step(); step();
    check("rst_ringing", ringing_57, 0);
    check("rst_armed", armed_57, 0);
    check("rst_buzzer", buzzer_57, 0);
    check("rst_snz", snooze_cnt_57, 0);
    rst_57 = 1'b0;
    step();

    // Latch 07:30:00 and arm
    write_clock_e_57 = 1'b1; step(); write_clock_e_57 = 1'b0;
    alarm_on_57 = 1'b1; step();
    check("armed", armed_57, 1);
    set_cur(7'd7, 7'd29, 7'd59); tick();
    check("no_early", ringing_57, 0);
    set_cur(7'd7, 7'd30, 7'd0); tick();
    check("ring_on", ringing_57, 1);
    check("ring_buz", buzzer_57, 1);
    check("ring_not_armed", armed_57, 0);
    set_cur(7'd7, 7'd30, 7'd1);

    // Buzzer: high for 4 cycles, low for 4, high again
    step(); step(); step();
    check("buz_hi_last", buzzer_57, 1);
    step();
    check("buz_lo", buzzer_57, 0);
    step(); step(); step(); step();
    check("buz_hi_again", buzzer_57, 1);

    // Timeout after 5 ticks
    tick(); tick(); tick(); tick();
    check("to_still_ring", ringing_57, 1);
    tick();
    check("to_ringing", ringing_57, 0);
    check("to_armed", armed_57, 1);
    check("to_buz", buzzer_57, 0);
    check("to_snz", snooze_cnt_57, 0);

    // Snooze sequence
    set_cur(7'd7, 7'd30, 7'd0); tick();
    check("ring2", ringing_57, 1);
    set_cur(7'd7, 7'd30, 7'd1);
    key_snooze_57 = 1'b1; step();
    check("snz_ringing", ringing_57, 0);
    check("snz_armed", armed_57, 1);
    check("snz_cnt1", snooze_cnt_57, 1);
    check("snz_buz", buzzer_57, 0);
    step(); step();
    check("snz_hold", snooze_cnt_57, 1);
    key_snooze_57 = 1'b0; step();
    tick(); tick();
    check("snz_wait", ringing_57, 0);
    tick();
    check("snz_back", ringing_57, 1);
    check("snz_back_buz", buzzer_57, 1);
    for (int i = 0; i < 2; i++) begin
      key_snooze_57 = 1'b1; step(); key_snooze_57 = 1'b0; step();
      tick(); tick(); tick();
    end
    check("snz_cnt3", snooze_cnt_57, 3);
    check("snz_ring3", ringing_57, 1);
    key_snooze_57 = 1'b1; step();
    check("snz_limit_ring", ringing_57, 1);
    check("snz_limit_cnt", snooze_cnt_57, 3);
    key_snooze_57 = 1'b0; step();

    // Stop and snooze together: stop wins
    key_stop_57 = 1'b1; key_snooze_57 = 1'b1; step();
    check("both_armed", armed_57, 1);
    check("both_ringing", ringing_57, 0);
    check("both_snz", snooze_cnt_57, 0);
    key_stop_57 = 1'b0; key_snooze_57 = 1'b0; step();

    // Stop within the matching second does not re-fire
    set_cur(7'd7, 7'd30, 7'd0); tick();
    check("ring3", ringing_57, 1);
    key_stop_57 = 1'b1; step(); key_stop_57 = 1'b0;
    check("stop_armed", armed_57, 1);
    step(); step(); step();
    check("no_refire", ringing_57, 0);

    // Latch while ringing, then disable
    tick();
    check("ring4", ringing_57, 1);
    set_hour_57 = 7'd8; set_min_57 = 7'd15; set_sec_57 = 7'd0;
    write_clock_e_57 = 1'b1; step(); write_clock_e_57 = 1'b0;
    check("latch_keep", ringing_57, 1);
    alarm_on_57 = 1'b0; step();
    check("off_ringing", ringing_57, 0);
    check("off_armed", armed_57, 0);
    check("off_buz", buzzer_57, 0);
    alarm_on_57 = 1'b1; step();
    check("rearm", armed_57, 1);
    tick();
    check("old_time", ringing_57, 0);
    set_cur(7'd8, 7'd15, 7'd0); tick();
    check("new_time", ringing_57, 1);

    // Asynchronous reset mid-ring with a snooze used
    set_cur(7'd8, 7'd15, 7'd1);
    key_snooze_57 = 1'b1; step(); key_snooze_57 = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_ring", ringing_57, 1);
    check("pre_rst_snz", snooze_cnt_57, 1);
    #3 rst_57 = 1'b1;
    #1;
    check("arst_ringing", ringing_57, 0);
    check("arst_buz", buzzer_57, 0);
    check("arst_armed", armed_57, 0);
    check("arst_snz", snooze_cnt_57, 0);
    step(); step();
    rst_57 = 1'b0;
    #1;
    check("post_rst_idle", armed_57, 0);
    step();
    check("post_rst_arm", armed_57, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
